scandoubler_rotate_port: RTL
============================

Name: scandoubler_rotate_port

Overview:
SDRAM-side responder for the rotating scandoubler's video ports.
- Serves vidin 16-word write bursts by pulling words with vidin_ack.
- Serves vidout 8-word read bursts by returning words with vidout_ack.
- Performs the cornerturn by address mapping and issues single-word accesses to a generic RAM controller port.
- Sits between the rotation scaler and the SDRAM controller.

Parameters:
HCNT_WIDTH, 10, row/column coordinate width; RAM address width = 2*HCNT_WIDTH+1.
WR_BURST, 16, words per vidin burst.
RD_BURST, 8, words per vidout burst.
SETTLE, 2, cycles from a vidin_ack until vidin_d/vidin_col are valid.

Ports:
clk_sys  in  1  system clock; sole clock.
reset_n  in  1  asynchronous active-low reset.
vidin_req  in  1  write burst pending.
vidin_frame  in  1  write frame buffer select.
vidin_row  in  HCNT_WIDTH  source row.
vidin_col  in  HCNT_WIDTH  source column; low 4 bits track the current word.
vidin_d  in  16  RGB565 write word.
vidin_ack  out  1  one-cycle pulse: word consumed.
vidout_req  in  1  read pending; may drop mid-row.
vidout_frame  in  1  read frame buffer select.
vidout_row  in  HCNT_WIDTH  output row.
vidout_col  in  HCNT_WIDTH  output column of the next burst.
vidout_d  out  16  read word.
vidout_ack  out  1  one-cycle pulse: vidout_d valid.
ram_req  out  1  access request; held until ram_ack.
ram_we  out  1  1 = write.
ram_addr  out  2*HCNT_WIDTH+1  word address.
ram_wdata  out  16  write data.
ram_ack  in  1  request accepted.
ram_rdata  in  16  read data.
ram_rvalid  in  1  read data valid; returns are in order.

Behaviour:
Reset values: all outputs 0; state IDLE; last_grant = read.

Address mapping:
- Write: {vidin_frame, vidin_col, vidin_row}.
- Read: {vidout_frame, vidout_row, col_base + issued}.
- col_base + issued wraps modulo 2^HCNT_WIDTH.

States:
- IDLE: arbitrates when any request is high. If both are pending, grant the opposite of last_grant, otherwise grant the pending side. Write goes to WR_SETTLE, read goes to RD_ISSUE. col_base latches vidout_col at grant.
- WR_SETTLE: counts SETTLE cycles. On the final cycle latch ram_wdata <= vidin_d and ram_addr, then go to WR_REQ.
- WR_REQ: ram_req=1, ram_we=1. On ram_ack, pulse vidin_ack the next cycle and increment wcount. If wcount reaches WR_BURST, or vidin_req is low at ram_ack, go to GAP. Otherwise return to WR_SETTLE.
- RD_ISSUE: ram_req=1, ram_we=0. On each ram_ack increment issued. When issued == RD_BURST, or vidout_req is low, deassert ram_req and go to RD_DRAIN. An already-presented request is held until acked.
- RD_DRAIN: wait until returned == issued, then go to GAP.
- GAP: 2 idle cycles so client req deassertion is seen, then IDLE.

Read return path:
- On each ram_rvalid, register vidout_d <= ram_rdata and pulse vidout_ack the next cycle (1-cycle latency).
- The return path runs concurrently with RD_ISSUE.
- Returned data is delivered even if vidout_req has dropped.

Arbitration rules:
- No preemption mid-burst. last_grant updates at grant.
- Counters are (log2(burst)+1) bits; wcount, issued and returned clear at grant.
- vidin_req asserted during a read burst waits; the client line buffer covers 2 bursts.

Reset mid-burst: asynchronous return to IDLE with outputs cleared. The RAM controller is reset alongside.

Optional Feature:
ROTATE_STATS_EN
- Defined: adds outputs stat_wr_bursts[15:0] and stat_rd_bursts[15:0]. These are saturating counts of completed bursts, cleared on any vidin_frame edge, with stat_overlap pulsing when both requests are pending at arbitration.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package scandoubler_rotate_pkg:
  - state enum (IDLE, WR_SETTLE, WR_REQ, RD_ISSUE, RD_DRAIN, GAP);
  - WR_BURST/RD_BURST defaults;
  - GAP_CYCLES = 2;
  - address-concatenation functions wr_addr() and rd_addr().
- Natural sub-module: scandoubler_rotate_rdtrack, the issued/returned counters plus the vidout_d/vidout_ack register stage.

Test Plan:
1. Single write burst: vidin_req=1, frame=0, row=5, col=0x20, data 0..15, ram_ack immediate -> 16 writes to {0,0x20+i,5} with data i; 16 vidin_ack pulses, each ≥3 cycles apart; then GAP.
2. Single read burst: vidout row=3, col=0x10, ram_rvalid 4 cycles after ack -> reads {1,3,0x10..0x17}; 8 vidout_ack pulses each 1 cycle after rvalid with matching data.
3. Both requests pending from reset -> write granted first (last_grant = read), then read. Repeat -> strict alternation.
4. vidout_req drops after the 3rd ram_ack -> no 4th request; all 3 returns delivered; then GAP then IDLE.
5. reset_n low mid write burst (word 7) -> ram_req, vidin_ack and vidout_ack all 0 immediately; after release, IDLE with no spurious ack.
6. ROTATE_STATS_EN: 4 write and 2 read bursts, then vidin_frame toggle -> counts 4/2 before the toggle, 0/0 after.

Source files
------------

// File: rtl/scandoubler_rotate_pkg.sv
// ------------------------------------------------------------------------
// scandoubler_rotate_pkg: shared states, defaults and address builders. Rev 1.0
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package scandoubler_rotate_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETTLE = 3'd1,
    WR_REQ    = 3'd2,
    RD_ISSUE  = 3'd3,
    RD_DRAIN  = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam int WR_BURST_DEF = 16;
  localparam int RD_BURST_DEF = 8;
  localparam int GAP_CYCLES   = 2;

  // Write side is stored transposed: the column becomes the row-major index.
  function automatic logic [63:0] wr_addr(input logic frame, input logic [31:0] row,
                                          input logic [31:0] col, input int hw);
    return ({63'd0, frame} << (2 * hw)) | ({32'd0, col} << hw) | {32'd0, row};
  endfunction

  function automatic logic [63:0] rd_addr(input logic frame, input logic [31:0] row,
                                          input logic [31:0] col, input int hw);
    return ({63'd0, frame} << (2 * hw)) | ({32'd0, row} << hw) | {32'd0, col};
  endfunction

endpackage

`default_nettype wire

// File: rtl/scandoubler_rotate_rdtrack.sv
// ------------------------------------------------------------------------
// scandoubler_rotate_rdtrack: read issue/return counters and vidout register stage. Rev 1.0
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module scandoubler_rotate_rdtrack #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_issue,
  input  logic          i_rvalid,
  input  logic [15:0]   i_rdata,
  output logic [CW-1:0] o_issued,
  output logic [CW-1:0] o_returned,
  output logic [15:0]   o_vidout_d,
  output logic          o_vidout_ack
);

  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_returned;
  logic [15:0]   r_vidout_d;
  logic          r_vidout_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued     <= '0;
      r_returned   <= '0;
      r_vidout_d   <= '0;
      r_vidout_ack <= 1'b0;
    end else begin
      if (i_clr) begin
        r_issued   <= '0;
        r_returned <= '0;
      end else begin
        if (i_issue)  r_issued   <= r_issued + 1'b1;
        if (i_rvalid) r_returned <= r_returned + 1'b1;
      end
      // Returns are forwarded regardless of whether the client still wants them.
      if (i_rvalid) r_vidout_d <= i_rdata;
      r_vidout_ack <= i_rvalid;
    end
  end

  assign o_issued     = r_issued;
  assign o_returned   = r_returned;
  assign o_vidout_d   = r_vidout_d;
  assign o_vidout_ack = r_vidout_ack;

endmodule

`default_nettype wire

// File: rtl/scandoubler_rotate_port.sv
// ------------------------------------------------------------------------
// scandoubler_rotate_port: SDRAM-side cornerturn responder for the rotating
// scandoubler; optional burst statistics under ROTATE_STATS_EN. Rev 1.0
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module scandoubler_rotate_port
  import scandoubler_rotate_pkg::*;
#(
  parameter int HCNT_WIDTH = 10,
  parameter int WR_BURST   = WR_BURST_DEF,
  parameter int RD_BURST   = RD_BURST_DEF,
  parameter int SETTLE     = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    vidin_req,
  input  logic                    vidin_frame,
  input  logic [HCNT_WIDTH-1:0]   vidin_row,
  input  logic [HCNT_WIDTH-1:0]   vidin_col,
  input  logic [15:0]             vidin_d,
  output logic                    vidin_ack,
  input  logic                    vidout_req,
  input  logic                    vidout_frame,
  input  logic [HCNT_WIDTH-1:0]   vidout_row,
  input  logic [HCNT_WIDTH-1:0]   vidout_col,
  output logic [15:0]             vidout_d,
  output logic                    vidout_ack,
`ifdef ROTATE_STATS_EN
  output logic [15:0]             stat_wr_bursts,
  output logic [15:0]             stat_rd_bursts,
  output logic                    stat_overlap,
`endif
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [2*HCNT_WIDTH:0]   ram_addr,
  output logic [15:0]             ram_wdata,
  input  logic                    ram_ack,
  input  logic [15:0]             ram_rdata,
  input  logic                    ram_rvalid
);

  localparam int AW  = 2 * HCNT_WIDTH + 1;
  localparam int WCW = $clog2(WR_BURST) + 1;
  localparam int RCW = $clog2(RD_BURST) + 1;
  localparam int SCW = $clog2(SETTLE) + 1;
  localparam int GCW = $clog2(GAP_CYCLES) + 1;

  localparam logic [WCW-1:0] c_wr_last     = WCW'(WR_BURST - 1);
  localparam logic [RCW-1:0] c_rd_last     = RCW'(RD_BURST - 1);
  localparam logic [SCW-1:0] c_settle_last = SCW'(SETTLE - 1);
  localparam logic [GCW-1:0] c_gap_last    = GCW'(GAP_CYCLES - 1);

  state_t                r_state, w_next;
  logic                  r_last_wr;
  logic [HCNT_WIDTH-1:0] r_col_base;
  logic [HCNT_WIDTH-1:0] r_rd_row;
  logic                  r_rd_frame;
  logic [WCW-1:0]        r_wcount;
  logic [SCW-1:0]        r_settle;
  logic [GCW-1:0]        r_gap;
  logic [15:0]           r_wdata;
  logic [AW-1:0]         r_wr_addr;
  logic                  r_vidin_ack;
  logic                  r_rd_hold;

  logic                  w_grant, w_grant_wr, w_ram_req, w_rd_issue;
  logic [RCW-1:0]        w_issued, w_returned;
  logic [HCNT_WIDTH-1:0] w_rd_col;
  logic [AW-1:0]         w_wr_addr, w_rd_addr;

  assign w_rd_col  = r_col_base + HCNT_WIDTH'(w_issued);
  assign w_wr_addr = AW'(wr_addr(vidin_frame, 32'(vidin_row), 32'(vidin_col), HCNT_WIDTH));
  assign w_rd_addr = AW'(rd_addr(r_rd_frame, 32'(r_rd_row), 32'(w_rd_col), HCNT_WIDTH));

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_wr = 1'b0;
    w_ram_req  = 1'b0;
    case (r_state)
      IDLE: begin
        if (vidin_req || vidout_req) begin
          w_grant    = 1'b1;
          w_grant_wr = vidin_req && (!vidout_req || !r_last_wr);
          w_next     = w_grant_wr ? WR_SETTLE : RD_ISSUE;
        end
      end
      WR_SETTLE: if (r_settle == c_settle_last) w_next = WR_REQ;
      WR_REQ: begin
        w_ram_req = 1'b1;
        if (ram_ack) w_next = (r_wcount == c_wr_last || !vidin_req) ? GAP : WR_SETTLE;
      end
      RD_ISSUE: begin
        // A request already on the bus stays up until the controller takes it.
        w_ram_req = r_rd_hold || vidout_req;
        if (w_ram_req && ram_ack) begin
          if (w_issued == c_rd_last || !vidout_req) w_next = RD_DRAIN;
        end else if (!w_ram_req) begin
          w_next = RD_DRAIN;
        end
      end
      RD_DRAIN: if (w_returned == w_issued) w_next = GAP;
      GAP:      if (r_gap == c_gap_last) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  assign w_rd_issue = (r_state == RD_ISSUE) && w_ram_req && ram_ack;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_wr   <= 1'b0;
      r_col_base  <= '0;
      r_rd_row    <= '0;
      r_rd_frame  <= 1'b0;
      r_wcount    <= '0;
      r_settle    <= '0;
      r_gap       <= '0;
      r_wdata     <= '0;
      r_wr_addr   <= '0;
      r_vidin_ack <= 1'b0;
      r_rd_hold   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last_wr  <= w_grant_wr;
        r_col_base <= vidout_col;
        r_rd_row   <= vidout_row;
        r_rd_frame <= vidout_frame;
        r_wcount   <= '0;
      end else if (r_state == WR_REQ && ram_ack) begin
        r_wcount <= r_wcount + 1'b1;
      end
      r_settle <= (r_state == WR_SETTLE) ? r_settle + 1'b1 : '0;
      r_gap    <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (r_state == WR_SETTLE && r_settle == c_settle_last) begin
        r_wdata   <= vidin_d;
        r_wr_addr <= w_wr_addr;
      end
      r_vidin_ack <= (r_state == WR_REQ) && ram_ack;
      r_rd_hold   <= (r_state == RD_ISSUE) && w_ram_req && !ram_ack;
    end
  end

  scandoubler_rotate_rdtrack #(
    .CW (RCW)
  ) u_rdtrack (
    .clk          (clk_sys),
    .rst_n        (reset_n),
    .i_clr        (w_grant),
    .i_issue      (w_rd_issue),
    .i_rvalid     (ram_rvalid),
    .i_rdata      (ram_rdata),
    .o_issued     (w_issued),
    .o_returned   (w_returned),
    .o_vidout_d   (vidout_d),
    .o_vidout_ack (vidout_ack)
  );

  assign vidin_ack = r_vidin_ack;
  assign ram_req   = w_ram_req;
  assign ram_we    = (r_state == WR_REQ);
  assign ram_addr  = (r_state == RD_ISSUE) ? w_rd_addr : r_wr_addr;
  assign ram_wdata = r_wdata;

`ifdef ROTATE_STATS_EN
  logic        r_frame_q;
  logic [15:0] r_stat_wr, r_stat_rd;
  logic        r_overlap;
  logic        w_wr_done, w_rd_done;

  assign w_wr_done = (r_state == WR_REQ) && (w_next == GAP);
  assign w_rd_done = (r_state == RD_DRAIN) && (w_next == GAP);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_q <= 1'b0;
      r_stat_wr <= '0;
      r_stat_rd <= '0;
      r_overlap <= 1'b0;
    end else begin
      r_frame_q <= vidin_frame;
      r_overlap <= (r_state == IDLE) && vidin_req && vidout_req;
      if (vidin_frame != r_frame_q) begin
        r_stat_wr <= '0;
        r_stat_rd <= '0;
      end else begin
        if (w_wr_done && r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 1'b1;
        if (w_rd_done && r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 1'b1;
      end
    end
  end

  assign stat_wr_bursts = r_stat_wr;
  assign stat_rd_bursts = r_stat_rd;
  assign stat_overlap   = r_overlap;
`endif

endmodule

`default_nettype wire
